piezo_tone_gen: RTL and testbench

//  Converts the 4-bit note code from the music sequencer (0 = rest, 1..8 = C4 D4 E4 F4 G4 A4 B4 C5)

---
 rtl/piezo_tone_gen.sv | 103 ++++++++++
 tb/tb_piezo_tone_gen.sv | 128 ++++++++++++
 2 files changed

// File: rtl/piezo_tone_gen.sv
// Piezo square-wave generator: filters the sequencer note code, looks up the
// half-period for the accepted note and toggles tone_out with clean phase restarts.
module piezo_tone_gen #(
    parameter int DIV_SHIFT = 0,
    parameter int CNT_W     = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] note_code,
    output logic       tone_out,
    output logic       tone_active,
    output logic       period_done,
    output logic [3:0] cur_note,
    output logic       code_err
);
    typedef enum logic {IDLE, TONE} state_t;

    state_t           state;
    logic [3:0]       q1, q2;
    logic [3:0]       mapped;
    logic             accept;
    logic             restart;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half_m1;

    function automatic logic [CNT_W-1:0] half_of(input logic [3:0] n);
        logic [CNT_W-1:0] hp;
        case (n)
            4'd1:    hp = CNT_W'(95556);
            4'd2:    hp = CNT_W'(85131);
            4'd3:    hp = CNT_W'(75843);
            4'd4:    hp = CNT_W'(71586);
            4'd5:    hp = CNT_W'(63776);
            4'd6:    hp = CNT_W'(56818);
            4'd7:    hp = CNT_W'(50619);
            4'd8:    hp = CNT_W'(47778);
            default: hp = CNT_W'(1);
        endcase
        hp = hp >> DIV_SHIFT;
        if (hp == '0) hp = CNT_W'(1);
        return hp;
    endfunction

    // Invalid codes collapse to rest; a code must match across both sync stages to be taken.
    always_comb begin
        mapped  = (q2 > 4'd8) ? 4'd0 : q2;
        accept  = (q1 == q2) && (mapped != cur_note);
        restart = accept && (mapped != 4'd0) && (cur_note != 4'd0);
        half_m1 = half_of(cur_note) - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q1          <= '0;
            q2          <= '0;
            cur_note    <= '0;
            code_err    <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            tone_out    <= 1'b0;
            tone_active <= 1'b0;
            period_done <= 1'b0;
        end else begin
            q1          <= note_code;
            q2          <= q1;
            code_err    <= (q2 > 4'd8);
            period_done <= 1'b0;
            if (accept) cur_note <= mapped;

            case (state)
                IDLE: begin
                    cnt         <= '0;
                    tone_out    <= 1'b0;
                    tone_active <= 1'b0;
                    if (cur_note != 4'd0 && enable) begin
                        state       <= TONE;
                        tone_active <= 1'b1;
                    end
                end
                TONE: begin
                    if (!enable || cur_note == 4'd0) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        tone_out    <= 1'b0;
                        tone_active <= 1'b0;
                    end else if (restart) begin
                        // New note lands this edge: start its first half-period from zero.
                        cnt      <= '0;
                        tone_out <= 1'b0;
                    end else if (cnt == half_m1) begin
                        cnt         <= '0;
                        tone_out    <= ~tone_out;
                        period_done <= tone_out;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_piezo_tone_gen.sv
// Directed bench for piezo_tone_gen at DIV_SHIFT=10 (C4=93, A4=55, C5=46 clk half-periods).
module tb_piezo_tone_gen;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] note_code;
    logic       tone_out, tone_active, period_done, code_err;
    logic [3:0] cur_note;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    piezo_tone_gen #(.DIV_SHIFT(10), .CNT_W(17)) dut (
        .clk(clk), .reset(reset), .enable(enable), .note_code(note_code),
        .tone_out(tone_out), .tone_active(tone_active), .period_done(period_done),
        .cur_note(cur_note), .code_err(code_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; note_code = 4'd6;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tone", tone_out, 0);
        chk("rst_active", tone_active, 0);
        chk("rst_pd", period_done, 0);
        chk("rst_note", cur_note, 0);
        chk("rst_err", code_err, 0);
        reset = 1'b0;

        // A4 from reset: accepted edge 3, TONE edge 4, rise 59, fall 114.
        run_to(2);   chk("a4_note_lat", cur_note, 0);
        run_to(3);   chk("a4_note", cur_note, 6);
        run_to(4);   chk("a4_active", tone_active, 1);
                     chk("a4_tone_start", tone_out, 0);
        run_to(58);  chk("a4_pre_rise", tone_out, 0);
        run_to(59);  chk("a4_rise", tone_out, 1);
                     chk("a4_no_pd_rise", period_done, 0);
        run_to(113); chk("a4_pre_fall", tone_out, 1);
        run_to(114); chk("a4_fall", tone_out, 0);
                     chk("a4_pd", period_done, 1);
        run_to(115); chk("a4_pd_pulse", period_done, 0);
        run_to(169); chk("a4_rise2", tone_out, 1);

        // Switch to C4 while high: phase restart at acceptance edge 183, next rise 276.
        run_to(180); note_code = 4'd1;
        run_to(182); chk("chg_hold_tone", tone_out, 1);
                     chk("chg_hold_note", cur_note, 6);
        run_to(183); chk("chg_note", cur_note, 1);
                     chk("chg_tone0", tone_out, 0);
        run_to(275); chk("c4_pre_rise", tone_out, 0);
        run_to(276); chk("c4_rise", tone_out, 1);

        // Rest: cur_note 0 at 279, tone drops on the following edge.
        note_code = 4'd0;
        run_to(279); chk("rest_note", cur_note, 0);
                     chk("rest_tone_lag", tone_out, 1);
        run_to(280); chk("rest_tone", tone_out, 0);
                     chk("rest_active", tone_active, 0);
                     chk("rest_pd", period_done, 0);

        // Single-cycle glitch of note 3 is filtered out.
        run_to(282); note_code = 4'd3;
        run_to(283); note_code = 4'd0;
        run_to(290); chk("glitch_note", cur_note, 0);
                     chk("glitch_tone", tone_out, 0);

        // C5 then invalid code 12: treated as rest, code_err raised.
        note_code = 4'd8;
        run_to(293); chk("c5_note", cur_note, 8);
        run_to(300); note_code = 4'd12;
        run_to(302); chk("inv_err_lat", code_err, 0);
                     chk("inv_note_lat", cur_note, 8);
        run_to(303); chk("inv_err", code_err, 1);
                     chk("inv_note", cur_note, 0);
        run_to(304); chk("inv_active", tone_active, 0);
                     chk("inv_tone", tone_out, 0);

        // C5 again, then mute for 20 clk; restart rises 46 clk after enable returns.
        note_code = 4'd8;
        run_to(306); chk("err_hold", code_err, 1);
        run_to(307); chk("err_clear", code_err, 0);
                     chk("c5b_note", cur_note, 8);
        run_to(353); chk("c5_pre_rise", tone_out, 0);
        run_to(354); chk("c5_rise", tone_out, 1);
                     chk("c5_active", tone_active, 1);
        run_to(360); enable = 1'b0;
        run_to(361); chk("mute_tone", tone_out, 0);
                     chk("mute_active", tone_active, 0);
                     chk("mute_pd", period_done, 0);
                     chk("mute_note", cur_note, 8);
        run_to(380); chk("mute_hold", tone_out, 0);
        enable = 1'b1;
        run_to(381); chk("unmute_active", tone_active, 1);
        run_to(426); chk("unmute_pre_rise", tone_out, 0);
        run_to(427); chk("unmute_rise", tone_out, 1);

        // Asynchronous reset between clock edges.
        #2 reset = 1'b1;
        #1;
        chk("areset_tone", tone_out, 0);
        chk("areset_active", tone_active, 0);
        chk("areset_note", cur_note, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
